// File: rtl/enum_type.sv
// Shared types for the game controller: action codes, transmit FSM states,
// ASCII constants and the action-to-character mapping used by control_tx.
package enum_type;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        LEFT       = 4'd1,
        RIGHT      = 4'd2,
        DOWN       = 4'd3,
        DROP       = 4'd4,
        HOLD       = 4'd5,
        ROTATE     = 4'd6,
        ROTATE_REV = 4'd7,
        BAR        = 4'd8,
        WAIT       = 4'd9
    } state_type;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        LOAD,
        PULSE,
        WAIT_START,
        WAIT_DONE
    } tx_state_t;

    localparam logic [7:0] ASCII_LEFT       = 8'h61; // 'a'
    localparam logic [7:0] ASCII_RIGHT      = 8'h64; // 'd'
    localparam logic [7:0] ASCII_DOWN       = 8'h73; // 's'
    localparam logic [7:0] ASCII_DROP       = 8'h77; // 'w'
    localparam logic [7:0] ASCII_HOLD       = 8'h63; // 'c'
    localparam logic [7:0] ASCII_ROTATE     = 8'h78; // 'x'
    localparam logic [7:0] ASCII_ROTATE_REV = 8'h7A; // 'z'
    localparam logic [7:0] ASCII_BAR        = 8'h62; // 'b'
    localparam logic [7:0] ASCII_S          = 8'h53; // 'S'
    localparam logic [7:0] ASCII_BANG       = 8'h21; // '!'
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_ZERO       = 8'h30;

    typedef struct packed {
        logic       valid;
        logic [7:0] ch;
    } action_code_t;

    // NONE, WAIT and unused codes come back with valid=0 and are never queued.
    function automatic action_code_t encode_action(input state_type a);
        action_code_t r;
        r.valid = 1'b1;
        r.ch    = 8'h00;
        case (a)
            LEFT:       r.ch = ASCII_LEFT;
            RIGHT:      r.ch = ASCII_RIGHT;
            DOWN:       r.ch = ASCII_DOWN;
            DROP:       r.ch = ASCII_DROP;
            HOLD:       r.ch = ASCII_HOLD;
            ROTATE:     r.ch = ASCII_ROTATE;
            ROTATE_REV: r.ch = ASCII_ROTATE_REV;
            BAR:        r.ch = ASCII_BAR;
            default:    r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: one shift per cycle, done pulses W+1 cycles
// after start. Only five BCD digits are kept, so wider inputs print mod 100000.
module bin2bcd #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         done,
    output logic [19:0]  bcd
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     sh_q, sh_d;
    logic [19:0]      bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Add-3 correction on every digit >= 5, then shift one bit in.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            sh_d  = bin;
            bcd_d = 20'd0;
            cnt_d = CNT_W'(W);
        end else if (cnt_q != '0) begin
            {bcd_d, sh_d} = {adj, sh_q} << 1;
            cnt_d         = cnt_q - 1'b1;
            done_d        = (cnt_q == CNT_W'(1));
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/control_tx.sv
// UART transmit companion: queues executed actions as single ASCII bytes and
// sends score updates as "Sddddd\r\n". A pending score line always wins over
// queued actions, and a line is never interleaved with action bytes.
module control_tx
    import enum_type::*;
#(
    parameter int QSIZE   = 16,
    parameter int SCORE_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ev_valid,
    input  state_type              ev,
    input  logic                   score_valid,
    input  logic [SCORE_W-1:0]     score,
    input  logic                   is_transmitting,
    output logic                   transmit,
    output logic [7:0]             tx_byte,
    output logic [$clog2(QSIZE):0] fifo_count,
    output logic                   dropped,
    output logic                   busy
);
    localparam int AW = $clog2(QSIZE);
    localparam int CW = AW + 1;

    logic [7:0]         fifo_mem [QSIZE];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               dropped_q, dropped_d;
    logic               score_pending_q, score_pending_d;
    logic [SCORE_W-1:0] score_hold_q, score_hold_d;

    tx_state_t          state_q;
    logic               transmit_q;
    logic [7:0]         tx_byte_q;
    logic [2:0]         idx_q;
    logic               line_q;

    action_code_t       ev_code;
    logic               full, empty, launch_ok, launch_score, launch_fifo, launch_bang;
    logic               push, pop;
    logic               bcd_done;
    logic [19:0]        bcd;
    logic [7:0]         msg [8];

    bin2bcd #(.W(SCORE_W)) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (launch_score),
        .bin   (score_hold_q),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Launch decisions, FIFO bookkeeping, drop flag and score capture.
    always_comb begin
        ev_code      = encode_action(ev);
        empty        = (count_q == '0);
        full         = (count_q == CW'(QSIZE));
        launch_ok    = (state_q == IDLE) && !is_transmitting;
        launch_score = launch_ok && score_pending_q;
        launch_fifo  = launch_ok && !score_pending_q && !empty;
        launch_bang  = launch_ok && !score_pending_q && empty && dropped_q;
        pop          = launch_fifo;
        push         = ev_valid && ev_code.valid && (!full || pop);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        dropped_d = dropped_q;
        if (launch_bang) dropped_d = 1'b0;
        if (ev_valid && ev_code.valid && full && !pop) dropped_d = 1'b1;

        // A strobe in the launch cycle wins, so the newer value waits for the next line.
        score_pending_d = score_pending_q;
        score_hold_d    = score_hold_q;
        if (launch_score) score_pending_d = 1'b0;
        if (score_valid) begin
            score_pending_d = 1'b1;
            score_hold_d    = score;
        end
    end

    // Byte sequence of a score line, indexed by idx_q.
    always_comb begin
        msg[0] = ASCII_S;
        msg[1] = ASCII_ZERO + {4'd0, bcd[19:16]};
        msg[2] = ASCII_ZERO + {4'd0, bcd[15:12]};
        msg[3] = ASCII_ZERO + {4'd0, bcd[11:8]};
        msg[4] = ASCII_ZERO + {4'd0, bcd[7:4]};
        msg[5] = ASCII_ZERO + {4'd0, bcd[3:0]};
        msg[6] = ASCII_CR;
        msg[7] = ASCII_LF;
    end

    // FIFO pointers, occupancy, drop flag and pending score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            dropped_q       <= 1'b0;
            score_pending_q <= 1'b0;
            score_hold_q    <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            dropped_q       <= dropped_d;
            score_pending_q <= score_pending_d;
            score_hold_q    <= score_hold_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= ev_code.ch;
    end

    // Transmit sequencer with registered transmit/tx_byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            idx_q      <= 3'd0;
            line_q     <= 1'b0;
        end else begin
            transmit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch_score) begin
                        line_q  <= 1'b1;
                        idx_q   <= 3'd0;
                        state_q <= CONVERT;
                    end else if (launch_fifo) begin
                        tx_byte_q  <= fifo_mem[rd_ptr_q];
                        transmit_q <= 1'b1;
                        line_q     <= 1'b0;
                        state_q    <= PULSE;
                    end else if (launch_bang) begin
                        tx_byte_q  <= ASCII_BANG;
                        transmit_q <= 1'b1;
                        line_q     <= 1'b0;
                        state_q    <= PULSE;
                    end
                end
                CONVERT: begin
                    if (bcd_done) state_q <= LOAD;
                end
                LOAD: begin
                    if (!is_transmitting) begin
                        tx_byte_q  <= msg[idx_q];
                        transmit_q <= 1'b1;
                        state_q    <= PULSE;
                    end
                end
                PULSE: begin
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (is_transmitting) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!is_transmitting) begin
                        if (line_q && idx_q != 3'd7) begin
                            idx_q      <= idx_q + 3'd1;
                            tx_byte_q  <= msg[idx_q + 3'd1];
                            transmit_q <= 1'b1;
                            state_q    <= PULSE;
                        end else begin
                            line_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign transmit   = transmit_q;
    assign tx_byte    = tx_byte_q;
    assign fifo_count = count_q;
    assign dropped    = dropped_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_control_tx.sv
// Directed bench for control_tx with a simple uart model that stays busy for
// 10 cycles after each transmit pulse; force_busy holds the uart busy on demand.
module tb_control_tx;
    import enum_type::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    state_type   ev;
    logic        score_valid;
    logic [15:0] score;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic [4:0]  fifo_count;
    logic        dropped;
    logic        busy;

    logic        force_busy = 1'b0;
    int          uart_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    int          peak = 0;
    logic [7:0]  rx_q [$];
    logic [7:0]  act_ascii [8] = '{8'h61, 8'h64, 8'h73, 8'h77, 8'h63, 8'h78, 8'h7A, 8'h62};

    always #5 clk = ~clk;

    control_tx #(.QSIZE(16), .SCORE_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .ev_valid        (ev_valid),
        .ev              (ev),
        .score_valid     (score_valid),
        .score           (score),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .fifo_count      (fifo_count),
        .dropped         (dropped),
        .busy            (busy)
    );

    assign is_transmitting = force_busy || (uart_cnt != 0);

    always @(posedge clk) begin
        if (transmit) uart_cnt <= 10;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end

    always @(negedge clk) begin
        if (transmit === 1'b1) rx_q.push_back(tx_byte);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || is_transmitting || fifo_count != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || is_transmitting || fifo_count != 0) begin
            failures++;
            $display("FAIL idle_timeout busy=%0b count=%0d required busy=0 count=0", busy, fifo_count);
        end
    endtask

    task automatic wait_bytes(input int cnt, input int budget);
        int n = 0;
        while (rx_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_q.size() < cnt) begin
            failures++;
            $display("FAIL byte_timeout got=%0d required=%0d", rx_q.size(), cnt);
        end
    endtask

    task automatic push_actions(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            ev_valid = 1'b1;
            ev       = state_type'(4'(1 + i % 8));
        end
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ev_valid = 1'b0; ev = NONE; score_valid = 1'b0; score = 16'd0;
        repeat (3) @(negedge clk);
        checks++; if (transmit !== 1'b0) begin failures++; $display("FAIL reset_transmit got=%b required=0", transmit); end
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h required=00", tx_byte); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d required=0", fifo_count); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b required=0", dropped); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        rx_q.delete();
        @(negedge clk); ev_valid = 1'b1; ev = WAIT;
        @(negedge clk); ev_valid = 1'b1; ev = LEFT;
        @(negedge clk); ev_valid = 1'b0;
        checks++; if (transmit !== 1'b0) begin failures++; $display("FAIL single_k1_transmit got=%b required=0", transmit); end
        checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d required=1", fifo_count); end
        @(negedge clk);
        checks++; if (transmit !== 1'b1) begin failures++; $display("FAIL single_k2_transmit got=%b required=1", transmit); end
        checks++; if (tx_byte !== 8'h61) begin failures++; $display("FAIL single_byte got=%h required=61", tx_byte); end
        @(negedge clk);
        checks++; if (transmit !== 1'b0) begin failures++; $display("FAIL single_k3_transmit got=%b required=0", transmit); end
        wait_idle(100);
        checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL single_pulses got=%0d required=1", rx_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b required=0", busy); end
    endtask

    task automatic test_burst;
        rx_q.delete();
        peak = 0;
        @(negedge clk); force_busy = 1'b1; ev_valid = 1'b1; ev = RIGHT;
        @(negedge clk); ev = ROTATE;
        @(negedge clk); ev = NONE;
        @(negedge clk); ev_valid = 1'b0;
        @(negedge clk); force_busy = 1'b0;
        wait_bytes(2, 100);
        wait_idle(100);
        checks++; if (rx_q.size() != 2) begin failures++; $display("FAIL burst_count got=%0d required=2", rx_q.size()); end
        checks++; if (rx_q[0] !== 8'h64) begin failures++; $display("FAIL burst_byte0 got=%h required=64", rx_q[0]); end
        checks++; if (rx_q[1] !== 8'h78) begin failures++; $display("FAIL burst_byte1 got=%h required=78", rx_q[1]); end
        checks++; if (peak != 2) begin failures++; $display("FAIL burst_peak got=%0d required=2", peak); end
    endtask

    task automatic test_score;
        logic [7:0] exp [16] = '{8'h53, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A,
                                 8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
        rx_q.delete();
        @(negedge clk); score_valid = 1'b1; score = 16'd1234;
        @(negedge clk); score_valid = 1'b0;
        wait_bytes(3, 200);
        @(negedge clk); score_valid = 1'b1; score = 16'd7;
        @(negedge clk); score_valid = 1'b0;
        wait_bytes(16, 600);
        wait_idle(100);
        checks++; if (rx_q.size() != 16) begin failures++; $display("FAIL score_len got=%0d required=16", rx_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx_q[i] !== exp[i]) begin
                failures++;
                $display("FAIL score_byte%0d got=%h required=%h", i, rx_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_overflow;
        rx_q.delete();
        @(negedge clk); force_busy = 1'b1;
        push_actions(18);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d required=16", fifo_count); end
        checks++; if (dropped !== 1'b1) begin failures++; $display("FAIL ovf_dropped got=%b required=1", dropped); end
        force_busy = 1'b0;
        wait_bytes(17, 600);
        wait_idle(100);
        checks++; if (rx_q.size() != 17) begin failures++; $display("FAIL ovf_len got=%0d required=17", rx_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx_q[i] !== act_ascii[i % 8]) begin
                failures++;
                $display("FAIL ovf_byte%0d got=%h required=%h", i, rx_q[i], act_ascii[i % 8]);
            end
        end
        checks++; if (rx_q[16] !== 8'h21) begin failures++; $display("FAIL ovf_bang got=%h required=21", rx_q[16]); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL ovf_dropped_clear got=%b required=0", dropped); end
    endtask

    task automatic test_full_pop;
        rx_q.delete();
        @(negedge clk); force_busy = 1'b1;
        push_actions(16);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL fullpop_pre got=%0d required=16", fifo_count); end
        force_busy = 1'b0; ev_valid = 1'b1; ev = BAR;
        @(negedge clk); ev_valid = 1'b0;
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL fullpop_count got=%0d required=16", fifo_count); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL fullpop_dropped got=%b required=0", dropped); end
        wait_bytes(17, 600);
        wait_idle(100);
        checks++; if (rx_q.size() != 17) begin failures++; $display("FAIL fullpop_len got=%0d required=17", rx_q.size()); end
        checks++; if (rx_q[0] !== 8'h61) begin failures++; $display("FAIL fullpop_first got=%h required=61", rx_q[0]); end
        checks++; if (rx_q[16] !== 8'h62) begin failures++; $display("FAIL fullpop_last got=%h required=62", rx_q[16]); end
    endtask

    task automatic test_reset_mid;
        rx_q.delete();
        @(negedge clk); score_valid = 1'b1; score = 16'd42;
        @(negedge clk); score_valid = 1'b0;
        wait_bytes(3, 200);
        @(negedge clk); ev_valid = 1'b1; ev = DOWN; score_valid = 1'b1; score = 16'd99;
        @(negedge clk); ev_valid = 1'b0; score_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL mid_queued got=%0d required=1", fifo_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b required=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (transmit !== 1'b0) begin failures++; $display("FAIL mid_rst_transmit got=%b required=0", transmit); end
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL mid_rst_tx_byte got=%h required=00", tx_byte); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL mid_rst_count got=%0d required=0", fifo_count); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL mid_rst_dropped got=%b required=0", dropped); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b required=0", busy); end
        rst = 1'b0;
        rx_q.delete();
        repeat (60) @(negedge clk);
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL mid_no_pulses got=%0d required=0", rx_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_score();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
